// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: multi-cycle mult/div with
// architectural HI/LO, plus mfhi/mflo/mthi/mtlo service.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDop,
  input  logic        valid,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_out
);

  localparam int NMAX =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(NMAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_wr;

  logic        is_arith;
  logic        is_div;
  logic        b_zero;
  logic        neg_a;
  logic        neg_b;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvs;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    is_arith = (MDop >= OP_MULT) && (MDop <= OP_DIVU);
    is_div   = (MDop == OP_DIV) || (MDop == OP_DIVU);
    start    = valid && is_arith && !busy;
    MD_out   = '0;
    if (valid) begin
      unique case (1'b1)
        (MDop == OP_MFHI): MD_out = HI;
        (MDop == OP_MFLO): MD_out = LO;
        default:           MD_out = '0;
      endcase
    end
  end

  // One shared multiplier; signedness is only in the operand extension.
  always_comb begin
    ext_a = {(MDop == OP_MULT) ? {32{A[31]}} : 32'd0, A};
    ext_b = {(MDop == OP_MULT) ? {32{B[31]}} : 32'd0, B};
    prod  = ext_a * ext_b;
  end

  // Signed divide on magnitudes so INT_MIN / -1 wraps to INT_MIN.
  always_comb begin
    neg_a  = (MDop == OP_DIV) && A[31];
    neg_b  = (MDop == OP_DIV) && B[31];
    mag_a  = neg_a ? -A : A;
    mag_b  = neg_b ? -B : B;
    b_zero = (B == 32'd0);
    dvs    = b_zero ? 32'd1 : mag_b;
    quo    = mag_a / dvs;
    rem    = mag_a % dvs;
    if (is_div) begin
      res_lo = (neg_a ^ neg_b) ? -quo : quo;
      res_hi = neg_a ? -rem : rem;
    end else begin
      res_lo = prod[31:0];
      res_hi = prod[63:32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      busy    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (start) begin
      cnt     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      busy    <= 1'b1;
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_wr <= !(is_div && b_zero);
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        if (pend_wr) begin
          HI <= pend_hi;
          LO <= pend_lo;
        end
      end
    end else if (valid) begin
      if (MDop == OP_MTHI) HI <= A;
      if (MDop == OP_MTLO) LO <= A;
    end
  end

  // Hazard unit must hold MD-class ops in D while busy.
  always_ff @(posedge clk) begin
    if (!reset && busy && valid) begin
      assert (!(is_arith || MDop == OP_MTHI || MDop == OP_MTLO))
        else $warning("md_unit: op %0d issued while busy, ignored", MDop);
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Randomized scoreboard bench for md_unit against a
// plain-arithmetic HI/LO reference model.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDop;
  logic        valid;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MD_out;

  int total = 0;
  int bad = 0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .MDop(MDop), .valid(valid),
    .A(A), .B(B), .start(start), .busy(busy),
    .HI(HI), .LO(LO), .MD_out(MD_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] ohi;
    logic [31:0] olo;
    int          n;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] rdq[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  bit          mon_prev;
  int          mon_run;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  // Reference: HI/LO after an op, straight from 64-bit arithmetic.
  function automatic void ref_md(input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi_i, input logic [31:0] lo_i,
                                 output logic [31:0] hi_o, output logic [31:0] lo_o);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint          p;
    longint unsigned up;
    hi_o = hi_i;
    lo_o = lo_i;
    case (op)
      4'd1: begin p = sa * sb; hi_o = p[63:32]; lo_o = p[31:0]; end
      4'd2: begin up = ua * ub; hi_o = up[63:32]; lo_o = up[31:0]; end
      4'd3: if (b != 0) begin lo_o = 32'(sa / sb); hi_o = 32'(sa % sb); end
      4'd4: if (b != 0) begin lo_o = 32'(ua / ub); hi_o = 32'(ua % ub); end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] sp[6] = '{32'd0, 32'd1, 32'd2, 32'hFFFFFFFF,
                           32'h80000000, 32'h7FFFFFFF};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 20));
    return $urandom();
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit v);
    logic [31:0] nh;
    logic [31:0] nl;
    bit          arith;
    exp_t        e;
    @(posedge clk);
    #1;
    valid = v;
    MDop  = op;
    A     = a;
    B     = b;
    arith = v && op >= 4'd1 && op <= 4'd4;
    if (arith) begin
      ref_md(op, a, b, m_hi, m_lo, nh, nl);
      e.hi  = nh;
      e.lo  = nl;
      e.ohi = m_hi;
      e.olo = m_lo;
      e.n   = (op >= 4'd3) ? DC : MC;
      sbq.push_back(e);
      m_hi = nh;
      m_lo = nl;
    end else if (v && op == 4'd5) rdq.push_back(m_hi);
    else if (v && op == 4'd6) rdq.push_back(m_lo);
    else if (v && op == 4'd7) m_hi = a;
    else if (v && op == 4'd8) m_lo = a;
    @(negedge clk);
    chk("start", 32'(start), 32'(arith));
    @(posedge clk);
    #1;
    valid = 1'b0;
    MDop  = 4'd0;
    A     = $urandom();
    B     = $urandom();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: busy still %0d after %0d cycles", busy, k);
    end
  endtask

  // Monitor: completion, busy length, hold-while-busy and MD_out.
  initial begin
    mon_prev = 1'b0;
    mon_run  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_prev = 1'b0;
        mon_run  = 0;
      end else begin
        if (busy) begin
          mon_run++;
          if (sbq.size() > 0) begin
            chk("hold_hi", HI, sbq[0].ohi);
            chk("hold_lo", LO, sbq[0].olo);
          end
        end else if (mon_prev) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL busy_unexpected: busy ran %0d cycles, want 0", mon_run);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("busy_len", 32'(mon_run), 32'(e.n));
            chk("res_hi", HI, e.hi);
            chk("res_lo", LO, e.lo);
          end
          mon_run = 0;
        end
        if (valid && (MDop == 4'd5 || MDop == 4'd6)) begin
          if (rdq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL md_out_unexpected: got %h want no read", MD_out);
          end else begin
            chk("md_out", MD_out, rdq.pop_front());
          end
        end else begin
          chk("md_out_zero", MD_out, 32'd0);
        end
        mon_prev = busy;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t want finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    MDop  = 4'd0;
    A     = '0;
    B     = '0;
    m_hi  = '0;
    m_lo  = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    issue(4'd1, 32'hFFFFFFFF, 32'h2, 1'b1);
    wait_idle();
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFE);

    issue(4'd2, 32'hFFFFFFFF, 32'h2, 1'b1);
    wait_idle();
    chk("multu_hi", HI, 32'h00000001);
    chk("multu_lo", LO, 32'hFFFFFFFE);

    issue(4'd3, 32'hFFFFFFF9, 32'h2, 1'b1);
    wait_idle();
    chk("div_hi", HI, 32'hFFFFFFFF);
    chk("div_lo", LO, 32'hFFFFFFFD);

    issue(4'd4, 32'd7, 32'd0, 1'b1);
    wait_idle();
    chk("divz_hi", HI, 32'hFFFFFFFF);
    chk("divz_lo", LO, 32'hFFFFFFFD);

    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_idle();
    chk("ovf_hi", HI, 32'd0);
    chk("ovf_lo", LO, 32'h80000000);

    issue(4'd7, 32'h12345678, 32'd0, 1'b1);
    chk("mthi_busy", 32'(busy), 32'd0);
    issue(4'd5, 32'd0, 32'd0, 1'b1);
    issue(4'd8, 32'h9ABCDEF0, 32'd0, 1'b1);
    chk("mtlo_busy", 32'(busy), 32'd0);
    issue(4'd6, 32'd0, 32'd0, 1'b1);

    // Ops forced in while busy must be dropped.
    issue(4'd3, 32'd100, 32'd7, 1'b1);
    valid = 1'b1;
    MDop  = 4'd1;
    A     = 32'd3;
    B     = 32'd5;
    @(negedge clk);
    chk("busy_mult_start", 32'(start), 32'd0);
    @(posedge clk);
    #1;
    MDop = 4'd7;
    A    = 32'hDEADBEEF;
    @(negedge clk);
    chk("busy_mthi_start", 32'(start), 32'd0);
    @(posedge clk);
    #1;
    valid = 1'b0;
    MDop  = 4'd0;
    wait_idle();
    chk("busy_div_hi", HI, 32'd2);
    chk("busy_div_lo", LO, 32'd14);

    issue(4'd3, 32'd50, 32'd3, 1'b0);
    chk("inv_busy", 32'(busy), 32'd0);
    issue(4'd5, 32'd0, 32'd0, 1'b1);
    issue(4'd6, 32'd0, 32'd0, 1'b1);

    // Reset lands with the divide counter at 6.
    issue(4'd3, 32'd1000, 32'd3, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    sbq.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue(4'd1, 32'd3, 32'd4, 1'b1);
    wait_idle();
    chk("post_rst_lo", LO, 32'd12);
    chk("post_rst_hi", HI, 32'd0);

    for (int i = 0; i < 80; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      bit          v;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) op = 4'($urandom_range(1, 4));
      v = ($urandom_range(0, 7) != 0);
      a = pick();
      b = pick();
      issue(op, a, b, v);
      wait_idle();
      if ($urandom_range(0, 2) == 0)
        issue(4'($urandom_range(5, 6)), 32'd0, 32'd0, 1'b1);
    end
    issue(4'd5, 32'd0, 32'd0, 1'b1);
    issue(4'd6, 32'd0, 32'd0, 1'b1);

    repeat (3) @(negedge clk);
    if (sbq.size() != 0 || rdq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: sb=%0d rd=%0d want 0", sbq.size(), rdq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
